// File: rtl/log2_frac_if.sv
// Operand/result bundle between an upstream normalize stage and log2_frac.
interface log2_frac_if #(
    parameter int WIDTH  = 16,
    parameter int FRAC_W = 8,
    parameter int NORM_W = $clog2(WIDTH)
);
    logic [WIDTH-1:0]         data_i;
    logic [NORM_W-1:0]        norm_i;
    logic                     valid_i;
    logic                     ready_o;
    logic [NORM_W+FRAC_W-1:0] log2_o;
    logic                     zero_o;
    logic                     valid_o;

    modport master (
        output data_i, norm_i, valid_i,
        input  ready_o, log2_o, zero_o, valid_o
    );

    modport slave (
        input  data_i, norm_i, valid_i,
        output ready_o, log2_o, zero_o, valid_o
    );
endinterface

// File: rtl/log2_frac.sv
// Iterative fixed-point log2: integer part from the norm count, one fraction bit per cycle by squaring.
// Optional LOG2_ROUND_EN adds a guard bit and rounds (saturating) instead of truncating.
module log2_frac #(
    parameter int WIDTH  = 16,
    parameter int FRAC_W = 8
) (
    input  logic           clock,
    input  logic           reset,
    log2_frac_if.slave     bus
);
    localparam int NORM_W = $clog2(WIDTH);
    localparam int RES_W  = NORM_W + FRAC_W;
`ifdef LOG2_ROUND_EN
    localparam int N = FRAC_W + 1;
`else
    localparam int N = FRAC_W;
`endif
    localparam int CNT_W = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [WIDTH-1:0]    x;
    logic [NORM_W-1:0]   int_field;
    logic                zero;
    logic [N-1:0]        frac;
    logic [CNT_W-1:0]    cnt;
    logic                ready;
    logic                ready_next;
    logic                valid;
    logic                valid_next;
    logic [RES_W-1:0]    log2_q;
    logic                zero_q;
    logic                accept;
    logic [WIDTH:0]      sq_hi;
    logic [WIDTH-2:0]    sq_unused;
    logic                bit_new;
    logic [WIDTH-1:0]    x_sq;
    logic [N:0]          frac_sh;
    logic [RES_W-1:0]    result;
`ifdef LOG2_ROUND_EN
    logic [RES_W:0]      rsum;
`endif

    assign accept = (state == IDLE) && ready && bus.valid_i;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) state_next = ITER;
                else        state_next = IDLE;
            end
            ITER: begin
                if (cnt == CNT_W'(N - 1)) state_next = DONE;
                else                      state_next = ITER;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode; ready stays low through the valid_o cycle, so it re-arms one cycle after.
    always_comb begin
        ready_next = 1'b0;
        valid_next = 1'b0;
        if ((state == IDLE) && !accept) ready_next = 1'b1;
        else                            ready_next = 1'b0;
        if (state == DONE) valid_next = 1'b1;
        else               valid_next = 1'b0;
    end

    // Squaring step: x in [1,2) with WIDTH-1 fraction bits, so x*x lies in [1,4).
    always_comb begin
        {sq_hi, sq_unused} = {{WIDTH{1'b0}}, x} * {{WIDTH{1'b0}}, x};
        bit_new = sq_hi[WIDTH];
        if (bit_new) x_sq = sq_hi[WIDTH:1];
        else         x_sq = sq_hi[WIDTH-1:0];
        frac_sh = {frac, bit_new};
    end

    // Final result formation.
    always_comb begin
`ifdef LOG2_ROUND_EN
        rsum = {1'b0, int_field, frac[N-1:1]} + {{RES_W{1'b0}}, frac[0]};
        if (rsum[RES_W]) result = {RES_W{1'b1}};
        else             result = rsum[RES_W-1:0];
`else
        result = {int_field, frac};
`endif
        if (zero) result = {RES_W{1'b0}};
        else      result = result;
    end

    // Operand capture and iteration datapath.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x         <= '0;
            int_field <= '0;
            zero      <= 1'b0;
            frac      <= '0;
            cnt       <= '0;
        end else if (accept) begin
            x         <= bus.data_i;
            int_field <= NORM_W'(WIDTH - 1) - bus.norm_i;
            zero      <= ~bus.data_i[WIDTH-1];
            frac      <= '0;
            cnt       <= '0;
        end else if (state == ITER) begin
            x    <= x_sq;
            frac <= frac_sh[N-1:0];
            cnt  <= cnt + CNT_W'(1);
        end else begin
            x    <= x;
            frac <= frac;
            cnt  <= cnt;
        end
    end

    // Registered outputs; result fields hold between pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ready  <= 1'b0;
            valid  <= 1'b0;
            log2_q <= '0;
            zero_q <= 1'b0;
        end else begin
            ready <= ready_next;
            valid <= valid_next;
            if (state == DONE) begin
                log2_q <= result;
                zero_q <= zero;
            end else begin
                log2_q <= log2_q;
                zero_q <= zero_q;
            end
        end
    end

    assign bus.ready_o = ready;
    assign bus.valid_o = valid;
    assign bus.log2_o  = log2_q;
    assign bus.zero_o  = zero_q;
endmodule
